// File: rtl/elevator_motion_if.sv
// Goal-selector <-> motion-controller link for the three-floor elevator.
// Define ELEVATOR_DOOR_HOLD_EN to add the door_hold signal.
interface elevator_motion_if;
    logic [1:0] gf;
    logic       req;
    logic [1:0] floor;
    logic       moving;
    logic       dir;
    logic       door_open;
    logic       arrived;
`ifdef ELEVATOR_DOOR_HOLD_EN
    logic       door_hold;
`endif

    modport master (
        output gf,
        output req,
`ifdef ELEVATOR_DOOR_HOLD_EN
        output door_hold,
`endif
        input  floor,
        input  moving,
        input  dir,
        input  door_open,
        input  arrived
    );

    modport slave (
        input  gf,
        input  req,
`ifdef ELEVATOR_DOOR_HOLD_EN
        input  door_hold,
`endif
        output floor,
        output moving,
        output dir,
        output door_open,
        output arrived
    );
endinterface

// File: rtl/elevator_motion.sv
// Elevator motion controller: floor-by-floor travel, door timing and arrival pulse.
// Optional feature macro: ELEVATOR_DOOR_HOLD_EN (adds door_hold to keep the door open).
module elevator_motion #(
    parameter logic [1:0]  labelF1       = 2'b00,
    parameter logic [1:0]  labelF2       = 2'b01,
    parameter logic [1:0]  labelF3       = 2'b10,
    parameter int unsigned TRAVEL_CYCLES = 8,
    parameter int unsigned DOOR_CYCLES   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    elevator_motion_if.slave bus
);

    localparam int unsigned TW = $clog2(TRAVEL_CYCLES);
    localparam int unsigned DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StMove, StDoor} state_e;

    state_e          r_state, w_state_d;
    logic [1:0]      r_floor, w_floor_d;
    logic            r_moving, w_moving_d;
    logic            r_dir, w_dir_d;
    logic            r_door_open, w_door_open_d;
    logic            r_arrived, w_arrived_d;
    logic [TW-1:0]   r_travel_cnt, w_travel_cnt_d;
    logic [DW-1:0]   r_door_cnt, w_door_cnt_d;

    logic            w_goal_valid;
    logic            w_seg_done;
    logic            w_door_done;
    logic            w_hold;
    logic [1:0]      w_floor_step;

    // Physical position (0 = bottom) so direction decisions work for any label encoding.
    function automatic logic [1:0] f_idx(input logic [1:0] f);
        if (f == labelF3)      return 2'd2;
        else if (f == labelF2) return 2'd1;
        else                   return 2'd0;
    endfunction

    function automatic logic [1:0] f_step(input logic [1:0] f, input logic up);
        if (up) return (f == labelF1) ? labelF2 : labelF3;
        else    return (f == labelF3) ? labelF2 : labelF1;
    endfunction

`ifdef ELEVATOR_DOOR_HOLD_EN
    assign w_hold = bus.door_hold;
`else
    assign w_hold = 1'b0;
`endif

    assign w_goal_valid = bus.req && (bus.gf != 2'b11);
    assign w_seg_done   = (r_travel_cnt == TRAVEL_LAST);
    assign w_door_done  = (r_door_cnt == DOOR_LAST) && !w_hold;
    assign w_floor_step = f_step(r_floor, r_dir);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_floor      <= labelF1;
            r_moving     <= 1'b0;
            r_dir        <= 1'b0;
            r_door_open  <= 1'b0;
            r_arrived    <= 1'b0;
            r_travel_cnt <= '0;
            r_door_cnt   <= '0;
        end else begin
            r_state      <= w_state_d;
            r_floor      <= w_floor_d;
            r_moving     <= w_moving_d;
            r_dir        <= w_dir_d;
            r_door_open  <= w_door_open_d;
            r_arrived    <= w_arrived_d;
            r_travel_cnt <= w_travel_cnt_d;
            r_door_cnt   <= w_door_cnt_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (w_goal_valid) w_state_d = (bus.gf == r_floor) ? StDoor : StMove;
            end
            StMove: begin
                if (w_seg_done) begin
                    if (!w_goal_valid)              w_state_d = StIdle;
                    else if (bus.gf == w_floor_step) w_state_d = StDoor;
                end
            end
            StDoor: begin
                if (w_door_done) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_floor_d      = r_floor;
        w_moving_d     = r_moving;
        w_dir_d        = r_dir;
        w_door_open_d  = r_door_open;
        w_arrived_d    = 1'b0;
        w_travel_cnt_d = r_travel_cnt;
        w_door_cnt_d   = r_door_cnt;
        case (r_state)
            StIdle: begin
                if (w_goal_valid) begin
                    if (bus.gf == r_floor) begin
                        w_door_open_d = 1'b1;
                        w_arrived_d   = 1'b1;
                        w_door_cnt_d  = '0;
                    end else begin
                        w_moving_d     = 1'b1;
                        w_dir_d        = f_idx(bus.gf) > f_idx(r_floor);
                        w_travel_cnt_d = '0;
                    end
                end
            end
            StMove: begin
                if (w_seg_done) begin
                    w_travel_cnt_d = '0;
                    w_floor_d      = w_floor_step;
                    if (!w_goal_valid) begin
                        w_moving_d = 1'b0;
                    end else if (bus.gf == w_floor_step) begin
                        w_moving_d    = 1'b0;
                        w_door_open_d = 1'b1;
                        w_arrived_d   = 1'b1;
                        w_door_cnt_d  = '0;
                    end else begin
                        // Covers both continuing and reversing for the next segment.
                        w_dir_d = f_idx(bus.gf) > f_idx(w_floor_step);
                    end
                end else begin
                    w_travel_cnt_d = r_travel_cnt + 1'b1;
                end
            end
            StDoor: begin
                if (w_hold) begin
                    w_door_cnt_d = '0;
                end else if (w_door_done) begin
                    w_door_open_d = 1'b0;
                    w_door_cnt_d  = '0;
                end else begin
                    w_door_cnt_d = r_door_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.floor     = r_floor;
    assign bus.moving    = r_moving;
    assign bus.dir       = r_dir;
    assign bus.door_open = r_door_open;
    assign bus.arrived   = r_arrived;

endmodule

// File: doc/elevator_motion.md
# elevator_motion

Motion controller for the three-floor elevator. It sits directly downstream of the goal-floor selector and consumes its 2-bit goal floor plus a request-pending flag. From these it sequences car travel floor by floor, opens the door on arrival, and reports current floor, motion and direction. Its `floor` and `moving` outputs feed back into the goal selector, and its `arrived` pulse clears the request LED of the floor just served.

## Interface
- `labelF1`, default 2'b00: encoding of floor 1 (bottom).
- `labelF2`, default 2'b01: encoding of floor 2.
- `labelF3`, default 2'b10: encoding of floor 3 (top). Encoding 2'b11 is invalid.
- `TRAVEL_CYCLES`, default 8: clock cycles to travel one floor (≥2).
- `DOOR_CYCLES`, default 4: clock cycles the door stays open (≥1).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `gf` input 2: goal floor from the goal selector.
- `req` input 1: any request LED lit (led1|led2|led3).
- `floor` output 2: current car floor, registered.
- `moving` output 1: car in motion, registered.
- `dir` output 1: 1 = up, 0 = down. Meaningful only while `moving`=1; otherwise it holds its last value.
- `door_open` output 1: door open, registered.
- `arrived` output 1: one-cycle pulse when the car stops at `gf`.
- `door_hold` input 1: present only with `DOOR_HOLD_EN`.

## Operation
- States: IDLE, MOVE, DOOR. Reset puts the block in IDLE with `floor`=labelF1 and `moving`=`dir`=`door_open`=`arrived`=0. The travel and door counters reset to 0.
- A goal is valid when `req`=1 and `gf`≠2'b11. Goals are never served while `req`=0.
- IDLE, valid goal with `gf`≠`floor`: go to MOVE, set `moving`=1, set `dir`=(`gf`>`floor`), clear the travel counter.
- IDLE, valid goal with `gf`=`floor`: go to DOOR, set `door_open`=1, pulse `arrived`, clear the door counter.
- IDLE, invalid goal: stay in IDLE, all outputs hold.
- MOVE: the travel counter increments each cycle. When it reaches TRAVEL_CYCLES-1, it is a floor step:
  - `floor` advances one floor in direction `dir`.
  - The counter clears.
- At each floor step, `gf` and `req` are resampled:
  - New floor = `gf` and goal valid: go to DOOR, `moving`=0, `door_open`=1, pulse `arrived`.
  - Goal invalid (`req`=0 or `gf`=2'b11): go to IDLE, `moving`=0, no `arrived`.
  - Goal valid, lies further in `dir`: stay in MOVE.
  - Goal valid, lies in the opposite direction: stay in MOVE, flip `dir` for the next segment.
- Mid-segment changes to `gf`/`req` are ignored. A segment always completes.
- `floor` saturates: it never goes above labelF3 or below labelF1. A step that would leave that range is an illegal state that must be unreachable; the assertion bench checks it.
- DOOR: the door counter increments each cycle. At DOOR_CYCLES-1, go to IDLE with `door_open`=0. Requests during DOOR are not acted on until IDLE.
- `arrived` is high for exactly one cycle per stop, on the cycle `door_open` first rises.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- Request-to-`moving`: 1 cycle (the first rising edge that samples a valid goal in IDLE).
- Per floor: `floor` changes TRAVEL_CYCLES edges after entering MOVE or after the previous step.
- Arrival: `floor` update, `moving`↓, `door_open`↑ and `arrived`↑ all occur on the same edge.
- Door: `door_open` high for DOOR_CYCLES cycles, then IDLE. The earliest next departure is 1 cycle later.
- Same-floor request: `door_open`/`arrived` rise 1 edge after the request is sampled.
- `rst_n` low mid-operation: all state and outputs take their reset values immediately and asynchronously. `floor` returns to labelF1 regardless of position, and the car is treated as re-homed. Operation resumes on the first edge after `rst_n` rises.

## Configuration
- `ELEVATOR_DOOR_HOLD_EN` defined: adds the `door_hold` input. While in DOOR with `door_hold`=1, the door counter is held at 0, so the door stays open. The DOOR_CYCLES count restarts from release.
- Macro undefined: no `door_hold` port, and the door always closes after exactly DOOR_CYCLES cycles.

## Test plan
- Reset: assert `rst_n`=0 → `floor`=00, `moving`=0, `door_open`=0, `arrived`=0; inputs have no effect while reset is held.
- F1→F3 (defaults), `gf`=10, `req`=1:
  - `moving`=1, `dir`=1 after 1 edge.
  - `floor`=01 after 8 more edges, `floor`=10 after 16.
  - On that same edge `moving`=0, `door_open`=1, `arrived`=1 for 1 cycle.
  - `door_open` drops after 4 cycles.
- Same floor: at F1 idle, `gf`=00, `req`=1 → `door_open`=1 and `arrived` pulse next edge, no motion, IDLE after 4 cycles.
- Invalid/withdrawn goal:
  - `gf`=11 with `req`=1 in IDLE → no state change.
  - F1→F3 with `req`=0 set mid-segment → car reaches `floor`=01, stops, `arrived`=0, IDLE.
- Reversal: F2→F3 with `gf` changed to 00 mid-segment → reaches 10, `dir` flips to 0, passes 01, arrives at 00 with one `arrived` pulse.
- Reset mid-move (F1→F3, during second segment) → outputs reset immediately, `floor`=00. With `ELEVATOR_DOOR_HOLD_EN`: `door_hold`=1 for 10 cycles in DOOR → door open 10+4 cycles.
